// File: rtl/clockgen_lock_supervisor.sv
`default_nettype none
// ============================================================================
// clockgen_lock_supervisor : MMCM reset/lock sequencer with staggered release
// Rev 1.0
// ============================================================================
module clockgen_lock_supervisor #(
   parameter int NUM_CH         = 2,
   parameter int RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int SETTLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES = 8,
   parameter int CNT_W          = 8,
   parameter int MODE_W         = 1
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              locked,
   input  logic [MODE_W-1:0] mode_sel,
   output logic              mmcm_reset,
   output logic [NUM_CH-1:0] domain_reset,
   output logic [MODE_W-1:0] mode_active,
   output logic              ready,
   output logic [2:0]        state,
   output logic [CNT_W-1:0]  relock_count,
   output logic [CNT_W-1:0]  timeout_count
);

   localparam logic [2:0] c_RESET_MMCM = 3'd0;
   localparam logic [2:0] c_WAIT_LOCK  = 3'd1;
   localparam logic [2:0] c_SETTLE     = 3'd2;
   localparam logic [2:0] c_RELEASE    = 3'd3;
   localparam logic [2:0] c_RUN        = 3'd4;

   localparam int c_REL_END = STAGGER_CYCLES * NUM_CH;
   localparam int c_MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int c_MAX_B   = (SETTLE_CYCLES > c_MAX_A) ? SETTLE_CYCLES : c_MAX_A;
   localparam int c_MAX_C   = (c_REL_END > c_MAX_B) ? c_REL_END : c_MAX_B;
   localparam int c_CW      = $clog2(c_MAX_C) + 1;

   localparam logic [c_CW-1:0]  c_RST_LAST    = c_CW'(RST_CYCLES - 1);
   localparam logic [c_CW-1:0]  c_TMO_LAST    = c_CW'(LOCK_TIMEOUT - 1);
   localparam logic [c_CW-1:0]  c_SETTLE_LAST = c_CW'(SETTLE_CYCLES - 1);
   localparam logic [c_CW-1:0]  c_REL_LAST    = c_CW'(c_REL_END);
   localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;

   logic              r_lock_s1, r_lock_s;
   logic [MODE_W-1:0] r_mode_s1, r_mode_s;
   logic [2:0]        r_state;
   logic [c_CW-1:0]   r_cnt;
   logic              r_mmcm_reset;
   logic [NUM_CH-1:0] r_domain_reset;
   logic [MODE_W-1:0] r_mode_active;
   logic              r_ready;
   logic [CNT_W-1:0]  r_relock;
   logic [CNT_W-1:0]  r_timeout;

   logic              w_mode_chg;
   logic              w_lol;
   logic              w_tmo;
   logic [2:0]        w_state_nxt;
   logic [c_CW-1:0]   w_cnt_nxt;
   logic              w_mmcm_nxt;
   logic              w_ready_nxt;
   logic [NUM_CH-1:0] w_domain_nxt;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_lock_s1 <= 1'b0;
         r_lock_s  <= 1'b0;
         r_mode_s1 <= '0;
         r_mode_s  <= '0;
      end else begin
         r_lock_s1 <= locked;
         r_lock_s  <= r_lock_s1;
         r_mode_s1 <= mode_sel;
         r_mode_s  <= r_mode_s1;
      end
   end

   assign w_mode_chg = (r_mode_s != r_mode_active);

   // State register; outputs are registered from their next values so they never glitch.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= c_RESET_MMCM;
         r_cnt          <= '0;
         r_mmcm_reset   <= 1'b1;
         r_domain_reset <= '1;
         r_mode_active  <= '0;
         r_ready        <= 1'b0;
         r_relock       <= '0;
         r_timeout      <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_mmcm_reset   <= w_mmcm_nxt;
         r_domain_reset <= w_domain_nxt;
         r_ready        <= w_ready_nxt;
         if (w_mode_chg) r_mode_active <= r_mode_s;
         if (w_lol && (r_relock != c_CNT_MAX)) r_relock <= r_relock + 1'b1;
         if (w_tmo && (r_timeout != c_CNT_MAX)) r_timeout <= r_timeout + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lol       = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         c_RESET_MMCM: if (r_cnt == c_RST_LAST) w_state_nxt = c_WAIT_LOCK;
         c_WAIT_LOCK: begin
            if (r_lock_s) begin
               w_state_nxt = c_SETTLE;
            end else if (r_cnt == c_TMO_LAST) begin
               w_tmo       = 1'b1;
               w_state_nxt = c_RESET_MMCM;
            end
         end
         c_SETTLE, c_RELEASE, c_RUN: begin
            if (!r_lock_s) begin
               w_lol       = 1'b1;
               w_state_nxt = c_RESET_MMCM;
            end else if ((r_state == c_SETTLE) && (r_cnt == c_SETTLE_LAST)) begin
               w_state_nxt = c_RELEASE;
            end else if ((r_state == c_RELEASE) && (r_cnt == c_REL_LAST)) begin
               w_state_nxt = c_RUN;
            end
         end
         default: w_state_nxt = c_RESET_MMCM;
      endcase
      // A mode change overrides everything and restarts the MMCM reset hold.
      if (w_mode_chg) begin
         w_state_nxt = c_RESET_MMCM;
         w_lol       = 1'b0;
         w_tmo       = 1'b0;
      end
      if (w_mode_chg || (w_state_nxt != r_state)) w_cnt_nxt = '0;
      else if (r_state == c_RUN)                  w_cnt_nxt = r_cnt;
      else                                        w_cnt_nxt = r_cnt + 1'b1;
   end

   always_comb begin
      w_mmcm_nxt   = (w_state_nxt == c_RESET_MMCM);
      w_ready_nxt  = (w_state_nxt == c_RUN);
      w_domain_nxt = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_state_nxt == c_RELEASE)
            w_domain_nxt[i] = r_domain_reset[i] && (w_cnt_nxt != c_CW'(STAGGER_CYCLES * (i + 1)));
         else if (w_state_nxt == c_RUN)
            w_domain_nxt[i] = r_domain_reset[i];
      end
   end

   assign mmcm_reset    = r_mmcm_reset;
   assign domain_reset  = r_domain_reset;
   assign mode_active   = r_mode_active;
   assign ready         = r_ready;
   assign state         = r_state;
   assign relock_count  = r_relock;
   assign timeout_count = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clockgen_lock_supervisor.sv
`default_nettype none
// ============================================================================
// tb_clockgen_lock_supervisor : directed + random bench with timestamp model
// Rev 1.0
// ============================================================================
module tb_clockgen_lock_supervisor;

   localparam int NUM_CH = 3;
   localparam int RSTC   = 4;
   localparam int TMO    = 32;
   localparam int SETL   = 8;
   localparam int STG    = 2;
   localparam int CNT_W  = 2;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk_in;
   logic              reset_n;
   logic              locked;
   logic [0:0]        mode_sel;
   logic              mmcm_reset;
   logic [NUM_CH-1:0] domain_reset;
   logic [0:0]        mode_active;
   logic              ready;
   logic [2:0]        state;
   logic [CNT_W-1:0]  relock_count;
   logic [CNT_W-1:0]  timeout_count;

   clockgen_lock_supervisor #(
      .NUM_CH(NUM_CH), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .SETTLE_CYCLES(SETL),
      .STAGGER_CYCLES(STG), .CNT_W(CNT_W), .MODE_W(1)
   ) dut (
      .clk_in(clk_in), .reset_n(reset_n), .locked(locked), .mode_sel(mode_sel),
      .mmcm_reset(mmcm_reset), .domain_reset(domain_reset), .mode_active(mode_active),
      .ready(ready), .state(state), .relock_count(relock_count),
      .timeout_count(timeout_count)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   // Reference model: phase plus the absolute cycle at which it was entered.
   int         cyc, m_enter, m_ph, m_rel, m_tmo;
   logic       m_ls1, m_ls;
   logic [0:0] m_ms1, m_ms, m_mact;

   // Environment MMCM: locks lock_delay cycles after its reset drops (-1 = never).
   int lock_delay = 10;
   int lk_cnt     = 0;
   int glitch     = 0;

   function automatic void m_reset();
      cyc = 0; m_enter = 0; m_ph = 0; m_rel = 0; m_tmo = 0;
      m_ls1 = 1'b0; m_ls = 1'b0; m_ms1 = 1'b0; m_ms = 1'b0; m_mact = 1'b0;
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic model_edge();
      int n_in, nph;
      bit restart;
      if (!reset_n) begin
         m_reset();
      end else begin
         n_in    = cyc - m_enter + 1;
         nph     = m_ph;
         restart = 1'b0;
         if (m_ms != m_mact) begin
            m_mact  = m_ms;
            nph     = 0;
            restart = 1'b1;
         end else begin
            case (m_ph)
               0: if (n_in == RSTC) nph = 1;
               1: begin
                  if (m_ls) nph = 2;
                  else if (n_in == TMO) begin nph = 0; m_tmo = sat(m_tmo + 1); end
               end
               default: begin
                  if (!m_ls) begin nph = 0; m_rel = sat(m_rel + 1); end
                  else if (m_ph == 2 && n_in == SETL) nph = 3;
                  else if (m_ph == 3 && n_in == STG * NUM_CH + 1) nph = 4;
               end
            endcase
         end
         if (restart || nph != m_ph) m_enter = cyc + 1;
         m_ph  = nph;
         m_ls  = m_ls1;
         m_ls1 = locked;
         m_ms  = m_ms1;
         m_ms1 = mode_sel;
         cyc++;
      end
   endtask

   function automatic logic [NUM_CH-1:0] exp_dr();
      logic [NUM_CH-1:0] r;
      int rel;
      r = '1;
      if (m_ph == 4) begin
         r = '0;
      end else if (m_ph == 3) begin
         rel = (cyc - m_enter) / STG;
         if (rel > NUM_CH) rel = NUM_CH;
         for (int i = 0; i < rel; i++) r[i] = 1'b0;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("state",         32'(state),         32'(m_ph));
      chk("mmcm_reset",    32'(mmcm_reset),    32'(m_ph == 0));
      chk("domain_reset",  32'(domain_reset),  32'(exp_dr()));
      chk("ready",         32'(ready),         32'(m_ph == 4));
      chk("mode_active",   32'(mode_active),   32'(m_mact));
      chk("relock_count",  32'(relock_count),  32'(m_rel));
      chk("timeout_count", 32'(timeout_count), 32'(m_tmo));
   endtask

   // Called at a falling edge: drive inputs, clock once, check at next falling edge.
   task automatic step();
      if (mmcm_reset) lk_cnt = 0;
      else if (lk_cnt < 1000) lk_cnt++;
      locked = (lock_delay >= 0) && !mmcm_reset && (lk_cnt > lock_delay) && (glitch == 0);
      if (glitch > 0) glitch--;
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
      check_all();
   endtask

   task automatic run_until_state(input int st, input int budget, input string tag);
      int n = 0;
      while (state !== 3'(st) && n < budget) begin step(); n++; end
      chk(tag, 32'(state), 32'(st));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"}, 32'(state),         32'd0);
      chk({tag, "_mmcm"},  32'(mmcm_reset),    32'd1);
      chk({tag, "_dr"},    32'(domain_reset),  32'h7);
      chk({tag, "_ready"}, 32'(ready),         32'd0);
      chk({tag, "_rel"},   32'(relock_count),  32'd0);
      chk({tag, "_tmo"},   32'(timeout_count), 32'd0);
      chk({tag, "_mode"},  32'(mode_active),   32'd0);
   endtask

   initial begin
      int n, rdy;
      int fall [NUM_CH];
      reset_n  = 1'b0;
      locked   = 1'b0;
      mode_sel = 1'b0;
      m_reset();
      @(negedge clk_in);
      check_reset_values("por");
      step();
      step();
      reset_n = 1'b1;

      // Nominal bring-up
      n = 0;
      while (mmcm_reset === 1'b1 && n < 50) begin n++; step(); end
      chk("mmcm_high_cycles", 32'(n), 32'd4);
      run_until_state(3, 100, "reach_release");
      rdy = -1;
      for (int i = 0; i < NUM_CH; i++) fall[i] = -1;
      for (int t = 1; t <= 10; t++) begin
         step();
         for (int i = 0; i < NUM_CH; i++)
            if (domain_reset[i] === 1'b0 && fall[i] < 0) fall[i] = t;
         if (ready === 1'b1 && rdy < 0) rdy = t;
      end
      for (int i = 0; i < NUM_CH; i++) chk($sformatf("fall_ch%0d", i), 32'(fall[i]), 32'(STG * (i + 1)));
      chk("ready_cycle", 32'(rdy), 32'd7);
      chk("nominal_rel", 32'(relock_count), 32'd0);
      chk("nominal_tmo", 32'(timeout_count), 32'd0);
      repeat (4) step();

      // Loss of lock in RUN
      glitch = 1;
      step(); step(); step();
      chk("lol_state", 32'(state), 32'd0);
      chk("lol_ready", 32'(ready), 32'd0);
      chk("lol_dr", 32'(domain_reset), 32'h7);
      chk("lol_rel", 32'(relock_count), 32'd1);
      run_until_state(4, 200, "lol_resequence");

      // Glitch in SETTLE
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      run_until_state(2, 200, "reach_settle");
      repeat (5) step();
      glitch = 1;
      step(); step(); step();
      chk("settle_glitch_state", 32'(state), 32'd0);
      chk("settle_glitch_rel", 32'(relock_count), 32'd1);
      chk("settle_glitch_dr", 32'(domain_reset), 32'h7);

      // Mode change during RELEASE after channel 0 released
      n = 0;
      while (domain_reset !== 3'b110 && n < 200) begin step(); n++; end
      chk("reach_ch0_release", 32'(domain_reset), 32'h6);
      mode_sel = 1'b1;
      step(); step(); step();
      chk("mode_active_1", 32'(mode_active), 32'd1);
      chk("mode_dr", 32'(domain_reset), 32'h7);
      chk("mode_state", 32'(state), 32'd0);
      chk("mode_rel", 32'(relock_count), 32'd1);
      run_until_state(4, 200, "mode_resequence");
      mode_sel = 1'b0;
      glitch   = 1;
      step(); step(); step();
      chk("mode_lol_active", 32'(mode_active), 32'd0);
      chk("mode_lol_state", 32'(state), 32'd0);
      chk("mode_lol_rel", 32'(relock_count), 32'd1);

      // Asynchronous reset mid-RELEASE
      run_until_state(3, 200, "reach_release2");
      #2 reset_n = 1'b0;
      #1 check_reset_values("async");
      m_reset();
      @(negedge clk_in);
      check_all();

      // Timeout / retry
      lock_delay = -1;
      step();
      reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         repeat (RSTC) step();
         chk($sformatf("tmo%0d_mmcm_low", k), 32'(mmcm_reset), 32'd0);
         repeat (TMO) step();
         chk($sformatf("tmo%0d_count", k), 32'(timeout_count), 32'(k > 3 ? 3 : k));
         chk($sformatf("tmo%0d_mmcm_high", k), 32'(mmcm_reset), 32'd1);
         chk($sformatf("tmo%0d_ready", k), 32'(ready), 32'd0);
      end

      // Random traffic
      reset_n = 1'b0;
      step();
      reset_n    = 1'b1;
      lock_delay = 5;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 63) == 0) glitch = $urandom_range(1, 3);
         if ($urandom_range(0, 299) == 0) mode_sel = ~mode_sel;
         if ($urandom_range(0, 99) == 0) lock_delay = $urandom_range(0, 40);
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clockgen_lock_supervisor.md
Name: clockgen_lock_supervisor

Overview:
- Parametrised reset/lock sequencer for the MMCM clock generators: a dot4x/col4x clockgen with a `locked` output and an active-high `reset` input.
- Runs on the raw board input clock and drives the MMCM reset. It waits for lock with a timeout and retry, lets the clock settle, then releases NUM_CH downstream domain resets in a staggered order.
- Re-sequences on loss of lock or on a video-standard mode change (NTSC/PAL clock configuration select). Exposes status and saturating event counters.

Parameters:
- NUM_CH, 2: number of downstream domain resets.
- RST_CYCLES, 16: cycles `mmcm_reset` is held high per attempt (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before retry (≥2).
- SETTLE_CYCLES, 1024: cycles `locked` must stay high before release (≥1).
- STAGGER_CYCLES, 8: spacing between successive channel releases (≥1).
- CNT_W, 8: width of the event counters.
- MODE_W, 1: width of the mode select.

Ports:
- clk_in, input, 1: board input clock; all logic is on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- locked, input, 1: MMCM lock, asynchronous. Synchronised internally with 2 FFs to give `locked_s`.
- mode_sel, input, MODE_W: requested clock mode. Quasi-static; synchronised internally with 2 FFs.
- mmcm_reset, output, 1: active-high reset to the MMCM RST pin.
- domain_reset, output, NUM_CH: active-high per-domain resets.
- mode_active, output, MODE_W: mode currently applied to the MMCM configuration mux.
- ready, output, 1: all domains released, state RUN.
- state, output, 3: encoding RESET_MMCM=0, WAIT_LOCK=1, SETTLE=2, RELEASE=3, RUN=4.
- relock_count, output, CNT_W: number of loss-of-lock events after WAIT_LOCK. Saturating.
- timeout_count, output, CNT_W: number of lock-timeout retries. Saturating.

Behaviour:
- **Reset values (reset_n low, asynchronous):**
  - state=RESET_MMCM, mmcm_reset=1, domain_reset=all 1, ready=0.
  - Counters=0, mode_active=0, internal cycle counter=0, sync FFs=0.
- **Cycle counter:** single, width clog2(max of all cycle parameters)+1. It clears on every state entry.
- **RESET_MMCM:**
  - mmcm_reset=1, all domain_reset=1.
  - After exactly RST_CYCLES cycles in the state, go to WAIT_LOCK. mmcm_reset is 0 from the first WAIT_LOCK cycle.
  - locked_s is ignored in this state.
- **WAIT_LOCK:**
  - If locked_s=1, go to SETTLE.
  - Else, when the counter reaches LOCK_TIMEOUT-1: timeout_count+1 (saturating at all-ones), go to RESET_MMCM.
  - If lock and timeout occur in the same cycle, lock wins.
- **SETTLE:**
  - After SETTLE_CYCLES consecutive cycles with locked_s=1, go to RELEASE.
- **RELEASE:**
  - domain_reset[i] falls at cycle STAGGER_CYCLES*(i+1) after RELEASE entry. Channel 0 releases first.
  - One cycle after domain_reset[NUM_CH-1] falls, go to RUN with ready=1.
- **RUN:** hold all outputs.
- **Loss of lock** (locked_s=0 in SETTLE, RELEASE or RUN):
  - Next cycle: all domain_reset=1, ready=0, relock_count+1 (saturating), state=RESET_MMCM.
- **Mode change** (synchronised mode_sel ≠ mode_active, any state):
  - Next cycle: mode_active ← mode_sel, all domain_reset=1, ready=0, state=RESET_MMCM, counter cleared.
  - No counter increments.
  - This takes priority over loss of lock and timeout in the same cycle.
  - A mode change during RESET_MMCM restarts the RST_CYCLES hold.
- **Glitch-free outputs:** domain_reset bits never deassert outside RELEASE. Once a bit is released it stays low until a loss-of-lock, mode-change or reset_n event.
- **reset_n mid-sequence:** immediate return to reset values. Counters are cleared.
- **Latency:**
  - External locked rising edge to SETTLE entry: 3 cycles (2 sync + 1 register).
  - mode_sel change to RESET_MMCM: 3 cycles.

Test Plan (NUM_CH=3, RST_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8, STAGGER_CYCLES=2, CNT_W=2):
- **Nominal bring-up:** release reset_n; model raises locked 10 cycles after mmcm_reset falls.
  - mmcm_reset high exactly 4 cycles.
  - domain_reset[0..2] fall 2, 4, 6 cycles after RELEASE entry.
  - ready=1 at cycle 7. Counters stay 0.
- **Timeout/retry:** locked held 0.
  - mmcm_reset re-pulses every 4+32 cycles.
  - timeout_count reads 1, 2, 3, 3 (saturated) after 4 timeouts. ready stays 0.
- **Loss of lock in RUN:** drop locked for 1 cycle after ready=1.
  - 3 cycles later: all domain_reset=1, ready=0, relock_count=1, state=0.
  - Full re-sequence completes once lock returns.
- **Glitch in SETTLE:** locked low for 1 cycle at SETTLE cycle 5.
  - relock_count=1, back to RESET_MMCM. No domain_reset deasserted.
- **Mode change:** mode_sel 0→1 during RELEASE after channel 0 is released.
  - mode_active=1 3 cycles later; channel 0 reasserted; relock_count unchanged.
  - Then mode_sel change plus lock drop in the same cycle: only the mode path is taken, and the counter is not incremented.
- **Async reset mid-RELEASE:** assert reset_n low between clock edges.
  - All outputs return to reset values immediately, without waiting for a clock edge.
